// File: rtl/num_pkg.sv
// Shared types and constants for the BCD digit-entry composer.
package num_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int unsigned BCD_MAX = 9;
  localparam int unsigned DIEZ    = 10;

endpackage

// File: rtl/num_composer_bcd_to_bin.sv
// Combinational tens/units BCD pair to binary: decenas*10 + unidades.
module bcd_to_bin
  import num_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned NUM_W   = 8
) (
  input  logic [DIGIT_W-1:0] decenas,
  input  logic [DIGIT_W-1:0] unidades,
  output logic [NUM_W-1:0]   numero
);

  localparam longint unsigned MAX_SUM = longint'(BCD_MAX * DIEZ + BCD_MAX);

  if ((64'd1 << NUM_W) <= MAX_SUM) begin : g_width_check
    $error("bcd_to_bin: NUM_W too narrow for 99");
  end

  logic [NUM_W-1:0] d_ext;
  logic [NUM_W-1:0] u_ext;

  // Times ten as shift-add: (d<<3) + (d<<1)
  always_comb begin
    d_ext  = NUM_W'(decenas);
    u_ext  = NUM_W'(unidades);
    numero = (d_ext << 3) + (d_ext << 1) + u_ext;
  end

endmodule

// File: rtl/num_composer.sv
// Calculator-style two-digit BCD entry, committed as binary over valid/ready.
// Optional: NUM_COMPOSER_AUTOCOMMIT_EN commits on the second legal digit.
module num_composer
  import num_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned NUM_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  output logic               digit_ready,
  input  logic               borrar,
  input  logic               retroceso,
  input  logic               enter,
  output logic [NUM_W-1:0]   numero,
  output logic               num_valid,
  input  logic               num_ready,
  output logic [DIGIT_W-1:0] decenas,
  output logic [DIGIT_W-1:0] unidades,
  output logic [1:0]         cuenta,
  output logic               error
);

  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] decenas_q, decenas_d;
  logic [DIGIT_W-1:0] unidades_q, unidades_d;
  logic [NUM_W-1:0]   numero_q, numero_d;
  logic               num_valid_q, num_valid_d;
  logic               error_q, error_d;
  logic [1:0]         cuenta_q, cuenta_d;

  logic [DIGIT_W-1:0] conv_dec;
  logic [DIGIT_W-1:0] conv_uni;
  logic [NUM_W-1:0]   conv_num;
  logic               digit_hs;
  logic               digit_legal;

  assign digit_ready = rst_n & ((state_q == EMPTY) | (state_q == ONE))
                       & ~borrar & ~retroceso & ~enter;
  assign digit_hs    = digit_valid & digit_ready;
  assign digit_legal = (digit <= DIGIT_W'(BCD_MAX));

  // Converter normally sees the stored digits; with autocommit it sees the
  // pair being formed by the incoming second digit.
  always_comb begin
    conv_dec = decenas_q;
    conv_uni = unidades_q;
`ifdef NUM_COMPOSER_AUTOCOMMIT_EN
    if (state_q == ONE && digit_hs) begin
      conv_dec = unidades_q;
      conv_uni = digit;
    end
`endif
  end

  bcd_to_bin #(
    .DIGIT_W (DIGIT_W),
    .NUM_W   (NUM_W)
  ) u_bcd_to_bin (
    .decenas  (conv_dec),
    .unidades (conv_uni),
    .numero   (conv_num)
  );

  always_comb begin
    state_d     = state_q;
    decenas_d   = decenas_q;
    unidades_d  = unidades_q;
    numero_d    = numero_q;
    num_valid_d = num_valid_q;
    cuenta_d    = cuenta_q;
    error_d     = 1'b0;

    if (borrar) begin
      state_d     = EMPTY;
      decenas_d   = '0;
      unidades_d  = '0;
      cuenta_d    = 2'd0;
      num_valid_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (digit_hs) begin
            if (digit_legal) begin
              unidades_d = digit;
              cuenta_d   = 2'd1;
              state_d    = ONE;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        ONE: begin
          if (retroceso) begin
            unidades_d = '0;
            cuenta_d   = 2'd0;
            state_d    = EMPTY;
          end else if (enter) begin
            numero_d    = conv_num;
            num_valid_d = 1'b1;
            state_d     = HOLD;
          end else if (digit_hs) begin
            if (digit_legal) begin
              decenas_d  = unidades_q;
              unidades_d = digit;
              cuenta_d   = 2'd2;
`ifdef NUM_COMPOSER_AUTOCOMMIT_EN
              numero_d    = conv_num;
              num_valid_d = 1'b1;
              state_d     = HOLD;
`else
              state_d     = TWO;
`endif
            end else begin
              error_d = 1'b1;
            end
          end
        end
        TWO: begin
          if (retroceso) begin
            unidades_d = decenas_q;
            decenas_d  = '0;
            cuenta_d   = 2'd1;
            state_d    = ONE;
          end else if (enter) begin
            numero_d    = conv_num;
            num_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          if (num_valid_q && num_ready) begin
            decenas_d   = '0;
            unidades_d  = '0;
            cuenta_d    = 2'd0;
            num_valid_d = 1'b0;
            state_d     = EMPTY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      decenas_q   <= '0;
      unidades_q  <= '0;
      numero_q    <= '0;
      num_valid_q <= 1'b0;
      error_q     <= 1'b0;
      cuenta_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      decenas_q   <= decenas_d;
      unidades_q  <= unidades_d;
      numero_q    <= numero_d;
      num_valid_q <= num_valid_d;
      error_q     <= error_d;
      cuenta_q    <= cuenta_d;
    end
  end

  assign numero    = numero_q;
  assign num_valid = num_valid_q;
  assign decenas   = decenas_q;
  assign unidades  = unidades_q;
  assign cuenta    = cuenta_q;
  assign error     = error_q;

endmodule
